// File: rtl/ram_rd_chk.sv
// Purpose: sweeps RAM read addresses 0..2**ADDR_W-1 while ram_rd_flag is high, realigns returned words with their address and (with RAM_RD_CHK_ERR_EN defined) checks data == zero-extended address.
// Latency: ram_rd_en follows ram_rd_flag by one cycle; rd_valid follows each issue by RD_LAT+1 cycles.
// Backpressure: none; one read issues every cycle in READ, returned words are never stalled, in-flight words drain after the flag drops.
module ram_rd_chk #(
    parameter int ADDR_W = 6,   // read address width, must not exceed DATA_W
    parameter int DATA_W = 8,   // RAM data width
    parameter int RD_LAT = 1    // RAM read latency in cycles, 1..3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ram_rd_flag,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_rd_addr,
    input  logic [DATA_W-1:0] ram_rd_data,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data_out,
    output logic [ADDR_W-1:0] rd_addr_out,
    output logic              pass_done,
    output logic              err_flag,
    output logic [7:0]        err_cnt
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_READ = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    // Sweep controller state and current issue address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    // Next state: sweep starts at 0, wraps with no gap, and returns to 0 when the flag drops
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        unique case (state_q)
            S_IDLE: begin
                addr_d = '0;
                if (ram_rd_flag) begin
                    state_d = S_READ;
                end
            end
            S_READ: begin
                if (ram_rd_flag) begin
                    addr_d = addr_q + ADDR_W'(1);
                end else begin
                    state_d = S_IDLE;
                    addr_d  = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                addr_d  = '0;
            end
        endcase
    end

    // The read port is a direct decode of the registered state, so it is glitch-free
    assign ram_rd_en   = (state_q == S_READ);
    assign ram_rd_addr = addr_q;

    // Issue-side delay line matching the RAM read latency
    logic [RD_LAT-1:0] en_pipe_q;
    logic [ADDR_W-1:0] addr_pipe_q [RD_LAT];
    logic              dly_en;
    logic [ADDR_W-1:0] dly_addr;

    // Shift enable and address along with the RAM's own pipeline
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_pipe_q <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                addr_pipe_q[i] <= '0;
            end
        end else begin
            en_pipe_q[0]   <= ram_rd_en;
            addr_pipe_q[0] <= ram_rd_addr;
            for (int i = 1; i < RD_LAT; i++) begin
                en_pipe_q[i]   <= en_pipe_q[i-1];
                addr_pipe_q[i] <= addr_pipe_q[i-1];
            end
        end
    end

    assign dly_en   = en_pipe_q[RD_LAT-1];
    assign dly_addr = addr_pipe_q[RD_LAT-1];

    logic              rd_valid_q;
    logic [DATA_W-1:0] rd_data_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic              pass_done_q;

    // Register each returned word with the address that produced it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
            rd_addr_q   <= '0;
            pass_done_q <= 1'b0;
        end else begin
            rd_valid_q  <= dly_en;
            pass_done_q <= dly_en && (dly_addr == {ADDR_W{1'b1}});
            if (dly_en) begin
                rd_data_q <= ram_rd_data;
                rd_addr_q <= dly_addr;
            end
        end
    end

    assign rd_valid    = rd_valid_q;
    assign rd_data_out = rd_data_q;
    assign rd_addr_out = rd_addr_q;
    assign pass_done   = pass_done_q;

`ifdef RAM_RD_CHK_ERR_EN
    logic [DATA_W-1:0] exp_word;
    logic              mismatch;
    logic              err_flag_q;
    logic [7:0]        err_cnt_q;

    // The writer stores each address zero-extended as its data word
    assign exp_word = DATA_W'(dly_addr);
    assign mismatch = dly_en && (ram_rd_data != exp_word);

    // Sticky error flag and saturating error count; only reset clears them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_flag_q <= 1'b0;
            err_cnt_q  <= '0;
        end else if (mismatch) begin
            err_flag_q <= 1'b1;
            if (err_cnt_q != 8'hFF) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
        end
    end

    assign err_flag = err_flag_q;
    assign err_cnt  = err_cnt_q;
`else
    assign err_flag = 1'b0;
    assign err_cnt  = 8'd0;
`endif

endmodule

// File: tb/tb_ram_rd_chk.sv
// Bench for ram_rd_chk: three instances with RD_LAT 1, 2 and 3 share clock, reset and read-start flag.
// Each instance has its own RAM model and scoreboard; vectors are applied from a table, corner cases by hand.
// Error outputs are expected to count only when RAM_RD_CHK_ERR_EN is defined, and to read 0 otherwise.
module tb_ram_rd_chk;

    localparam int NI = 3;
`ifdef RAM_RD_CHK_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic flag;
    int   bad;     // 0: clean data, 1: addr 10 returns 8'hFF, 2: every word inverted

    logic       en_w   [NI];
    logic [5:0] addr_w [NI];
    logic [7:0] rdat_w [NI];
    logic       vld_w  [NI];
    logic [7:0] dout_w [NI];
    logic [5:0] aout_w [NI];
    logic       pd_w   [NI];
    logic       ef_w   [NI];
    logic [7:0] ec_w   [NI];

    function automatic logic [7:0] ram_word(input logic [5:0] a, input int mode);
        logic [7:0] w;
        w = {2'b00, a};
        if (mode == 1 && a == 6'd10) w = 8'hFF;
        if (mode == 2) w = ~w;
        return w;
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int LAT = g + 1;
        logic [7:0] rp [LAT];

        // RAM read port with LAT cycles of latency
        always @(posedge clk) begin
            rp[0] <= ram_word(addr_w[g], bad);
            for (int k = 1; k < LAT; k++) rp[k] <= rp[k-1];
        end
        assign rdat_w[g] = rp[LAT-1];

        ram_rd_chk #(.ADDR_W(6), .DATA_W(8), .RD_LAT(LAT)) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .ram_rd_flag (flag),
            .ram_rd_en   (en_w[g]),
            .ram_rd_addr (addr_w[g]),
            .ram_rd_data (rdat_w[g]),
            .rd_valid    (vld_w[g]),
            .rd_data_out (dout_w[g]),
            .rd_addr_out (aout_w[g]),
            .pass_done   (pd_w[g]),
            .err_flag    (ef_w[g]),
            .err_cnt     (ec_w[g])
        );
    end

    // Reference issue sequence derived from the flag alone
    logic       m_en;
    logic [5:0] m_addr;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_en   <= 1'b0;
            m_addr <= 6'd0;
        end else if (flag) begin
            m_addr <= m_en ? m_addr + 6'd1 : 6'd0;
            m_en   <= 1'b1;
        end else begin
            m_en   <= 1'b0;
            m_addr <= 6'd0;
        end
    end

    typedef struct {
        logic [5:0] a;
        logic [7:0] d;
    } sb_t;

    sb_t        sbq [NI][$];
    int         m_cnt  [NI];
    bit         m_flag [NI];
    logic [5:0] last_a [NI];
    int         n_ret  [NI];

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input int inst, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s lat%0d: got %0d, want %0d (t=%0t)", nm, inst + 1, act, exp, $time);
        end
    endtask

    // Per-cycle checks, run mid-cycle: issue port, returned words, error status
    task automatic sb_cycle();
        sb_t e;
        for (int i = 0; i < NI; i++) begin
            if (!rst_n) begin
                sbq[i].delete();
                m_cnt[i]  = 0;
                m_flag[i] = 1'b0;
            end else begin
                chk("ram_rd_en", i, en_w[i], m_en);
                chk("ram_rd_addr", i, addr_w[i], m_addr);
                if (vld_w[i]) begin
                    n_ret[i]++;
                    chk("valid_expected", i, sbq[i].size() > 0, 1);
                    if (sbq[i].size() > 0) begin
                        e = sbq[i].pop_front();
                        chk("rd_addr_out", i, aout_w[i], e.a);
                        chk("rd_data_out", i, dout_w[i], e.d);
                        chk("pass_done", i, pd_w[i], e.a == 6'd63);
                        last_a[i] = e.a;
                        if (ERR_EN && e.d != {2'b00, e.a}) begin
                            m_flag[i] = 1'b1;
                            if (m_cnt[i] < 255) m_cnt[i]++;
                        end
                    end
                end else begin
                    chk("pass_done_idle", i, pd_w[i], 0);
                end
                chk("err_flag", i, ef_w[i], m_flag[i]);
                chk("err_cnt", i, ec_w[i], m_cnt[i]);
                if (m_en) begin
                    e.a = m_addr;
                    e.d = ram_word(m_addr, bad);
                    sbq[i].push_back(e);
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        sb_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_port(input string nm, input bit exp_en, input int exp_addr);
        for (int i = 0; i < NI; i++) begin
            chk({nm, "_en"}, i, en_w[i], exp_en);
            chk({nm, "_addr"}, i, addr_w[i], exp_addr);
        end
    endtask

    typedef struct {
        bit rst_n;
        bit flag;
        int bad;
        int cycles;
        bit exp_en;
        int exp_addr;
        int exp_err;
        bit chk_drain;
    } vec_t;

    vec_t vecs [8];

    initial begin
        // rst_n, flag, bad, cycles, exp_en, exp_addr, exp_err (error build), drain check
        vecs[0] = '{1'b0, 1'b0, 0,   3, 1'b0,  0,   0, 1'b1};
        vecs[1] = '{1'b1, 1'b0, 0,  20, 1'b0,  0,   0, 1'b1};
        vecs[2] = '{1'b1, 1'b1, 0,   1, 1'b1,  0,   0, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 0,  64, 1'b1,  0,   0, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 1, 192, 1'b1,  0,   3, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 0,   8, 1'b0,  0,   3, 1'b1};
        vecs[6] = '{1'b1, 1'b1, 2, 300, 1'b1, 43, 255, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 0,  10, 1'b0,  0, 255, 1'b1};

        for (int i = 0; i < NI; i++) begin
            m_cnt[i]  = 0;
            m_flag[i] = 1'b0;
            last_a[i] = 6'd0;
            n_ret[i]  = 0;
        end
        rst_n = 1'b1;
        flag  = 1'b0;
        bad   = 0;
        #2;

        for (int v = 0; v < 8; v++) begin
            rst_n = vecs[v].rst_n;
            flag  = vecs[v].flag;
            bad   = vecs[v].bad;
            repeat (vecs[v].cycles) tick();
            chk_port("vec", vecs[v].exp_en, vecs[v].exp_addr);
            for (int i = 0; i < NI; i++) begin
                chk("vec_err_cnt", i, ec_w[i], ERR_EN ? vecs[v].exp_err : 0);
                chk("vec_err_flag", i, ef_w[i], ERR_EN ? (vecs[v].exp_err != 0) : 0);
                if (vecs[v].chk_drain) chk("vec_drain", i, sbq[i].size(), 0);
            end
        end

        // Flag drops while address 40 is issued: in-flight words drain, then restart at 0
        for (int i = 0; i < NI; i++) n_ret[i] = 0;
        flag = 1'b1;
        repeat (41) tick();
        chk_port("drop40_issue", 1'b1, 40);
        flag = 1'b0;
        tick();
        chk_port("drop40_idle", 1'b0, 0);
        repeat (7) tick();
        for (int i = 0; i < NI; i++) begin
            chk("drop40_last", i, last_a[i], 40);
            chk("drop40_count", i, n_ret[i], 41);
            chk("drop40_drain", i, sbq[i].size(), 0);
            chk("drop40_valid_low", i, vld_w[i], 0);
        end
        flag = 1'b1;
        tick();
        chk_port("restart", 1'b1, 0);
        repeat (30) tick();
        chk_port("midpass", 1'b1, 30);

        // Reset mid-pass: outputs clear at once, nothing returns after release
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            chk("rst_en", i, en_w[i], 0);
            chk("rst_addr", i, addr_w[i], 0);
            chk("rst_valid", i, vld_w[i], 0);
            chk("rst_data", i, dout_w[i], 0);
            chk("rst_aout", i, aout_w[i], 0);
            chk("rst_pass_done", i, pd_w[i], 0);
            chk("rst_err_flag", i, ef_w[i], 0);
            chk("rst_err_cnt", i, ec_w[i], 0);
        end
        flag = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        for (int i = 0; i < NI; i++) n_ret[i] = 0;
        repeat (10) tick();
        for (int i = 0; i < NI; i++) chk("post_rst_no_valid", i, n_ret[i], 0);
        chk_port("post_rst", 1'b0, 0);

        // Wrap address issued on the same edge the flag drops
        for (int i = 0; i < NI; i++) n_ret[i] = 0;
        flag = 1'b1;
        repeat (64) tick();
        chk_port("wrap_issue", 1'b1, 63);
        flag = 1'b0;
        tick();
        chk_port("wrap_drop", 1'b0, 0);
        repeat (7) tick();
        for (int i = 0; i < NI; i++) begin
            chk("wrap_last", i, last_a[i], 63);
            chk("wrap_count", i, n_ret[i], 64);
            chk("wrap_drain", i, sbq[i].size(), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
